lsu_dmem_ctrl: RTL and testbench

- Load/store unit between the riscv32i execute stage and the word-wide, big-endian data memory.
- Accepts one byte, halfword or word load/store request at a time and drives the memory's read/write, address and write-data inputs.
- Formats the memory read word into a sign- or zero-extended result.
- Memory has no byte enables, so sub-word stores use an internal read-modify-write sequence.

---
 rtl/lsu_dmem_ctrl_if.sv | 34 +++
 rtl/lsu_dmem_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_ctrl_if.sv
// Request, response and data-memory signal bundle for lsu_dmem_ctrl.
// The LSU takes the slave side; the execute stage and memory take the master side.
interface lsu_dmem_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_r_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_r_w, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_r_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit for a word-wide big-endian memory without byte enables.
// Define LSU_MISALIGN_ERR_EN to report misaligned/illegal requests instead of aligning them down.
module lsu_dmem_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic            clk,
  input logic            rst_n,
  lsu_dmem_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | req_ready high, waiting for a request
  // RD    | word address on the memory, read in flight
  // CAP   | read word arriving: format load result or merge store lane
  // WR    | raise the single write pulse
  // RSP   | first cycle raises rsp_valid, then wait for rsp_ready
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_e;

  state_e        state_q;
  logic          req_ready_q, rsp_valid_q, rsp_err_q, mem_r_w_q;
  logic [DW-1:0] rsp_rdata_q, mem_wdata_q, wdata_q;
  logic [AW-1:0] mem_addr_q;
  logic          we_q, uns_q, err_q;
  logic [1:0]    size_q, off_q;

  logic          req_err;
  logic [1:0]    size_n, off_n;
  logic [4:0]    byte_sh, half_sh;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] ld_data, st_data;

  always_comb begin
`ifdef LSU_MISALIGN_ERR_EN
    size_n  = bus.req_size;
    req_err = (bus.req_size == 2'b11) ||
              ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    size_n  = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    req_err = 1'b0;
`endif
    case (size_n)
      2'b00:   off_n = bus.req_addr[1:0];
      2'b01:   off_n = {bus.req_addr[1], 1'b0};
      default: off_n = 2'b00;
    endcase
  end

  // Big-endian: offset 0 is the most significant lane.
  always_comb begin
    byte_sh = {~off_q, 3'b000};
    half_sh = {~off_q[1], 4'b0000};
    rd_byte = 8'(bus.mem_rdata >> byte_sh);
    rd_half = 16'(bus.mem_rdata >> half_sh);
    case (size_q)
      2'b00: begin
        ld_data = {{(DW-8){~uns_q & rd_byte[7]}}, rd_byte};
        st_data = (bus.mem_rdata & ~(DW'(8'hFF) << byte_sh)) |
                  (DW'(wdata_q[7:0]) << byte_sh);
      end
      2'b01: begin
        ld_data = {{(DW-16){~uns_q & rd_half[15]}}, rd_half};
        st_data = (bus.mem_rdata & ~(DW'(16'hFFFF) << half_sh)) |
                  (DW'(wdata_q[15:0]) << half_sh);
      end
      default: begin
        ld_data = bus.mem_rdata;
        st_data = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_r_w_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            uns_q       <= bus.req_unsigned;
            size_q      <= size_n;
            off_q       <= off_n;
            wdata_q     <= bus.req_wdata;
            err_q       <= req_err;
            if (req_err) begin
              state_q <= S_RSP;
            end else begin
              mem_addr_q <= {bus.req_addr[AW-1:2], 2'b00};
              if (bus.req_we && (size_n == 2'b10)) begin
                mem_wdata_q <= bus.req_wdata;
                state_q     <= S_WR;
              end else begin
                state_q <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          mem_r_w_q <= 1'b0;
          state_q   <= S_CAP;
        end
        S_CAP: begin
          if (we_q) begin
            mem_wdata_q <= st_data;
            state_q     <= S_WR;
          end else begin
            rsp_rdata_q <= ld_data;
            state_q     <= S_RSP;
          end
        end
        S_WR: begin
          mem_r_w_q <= 1'b1;
          state_q   <= S_RSP;
        end
        S_RSP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            mem_r_w_q   <= 1'b0;
            if (err_q && !we_q) rsp_rdata_q <= '0;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_r_w   = mem_r_w_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed cases plus random traffic against a byte-array model.
module tb_lsu_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   wr_cyc = 0;

  lsu_dmem_ctrl_if #(.AW(32), .DW(32)) bus_if ();

  lsu_dmem_ctrl #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read word memory with a backdoor preload port
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic [5:0]  widx;
  assign widx = 6'((bus_if.mem_addr >> 2) & 32'h3F);

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (bus_if.mem_r_w) begin
      mem[widx] <= bus_if.mem_wdata;
      wr_cnt    <= wr_cnt + 1;
      wr_cyc    <= cyc + 1;
    end
    bus_if.mem_rdata <= mem[widx];
  end

  // Reference: big-endian byte array
  logic [7:0]  ref_b [256];
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr & 32'hFC);
    return {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]};
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    int a;
    a = int'(addr & 32'hFC);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 6'(a >> 2); pl_data = w;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[a+i] = w[31-8*i -: 8];
  endtask

  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat, output int wrs);
    int a, nb, szi;
    logic [31:0] v;
    a = int'(addr & 32'hFF);
    szi = int'(sz);
`ifdef LSU_MISALIGN_ERR_EN
    err = (szi == 3) || (szi == 1 && (a % 2) != 0) || (szi == 2 && (a % 4) != 0);
`else
    err = 1'b0;
    if (szi == 3) szi = 2;
    if (szi == 1) a = a - (a % 2);
    if (szi == 2) a = a - (a % 4);
`endif
    nb = 1 << szi;
    rd = 32'h0; wrs = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_b[a+i]);
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd = v;
      lat = 3;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[a+i] = 8'(wd >> (8*(nb-1-i)));
      lat = (nb == 4) ? 2 : 4;
      wrs = 1;
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat, e_wr, n, edges, w0;
    model(we, sz, uns, addr, wd, e_err, e_rd, e_lat, e_wr);
    @(negedge clk);
    check_val("req_ready_idle", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_size = sz;
    bus_if.req_unsigned = uns; bus_if.req_addr = addr; bus_if.req_wdata = wd;
    bus_if.rsp_ready = 1'b0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    n = cyc;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'($urandom);
    bus_if.req_size = 2'($urandom); bus_if.req_addr = $urandom; bus_if.req_wdata = $urandom;
    check_val("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
    edges = 0;
    while (!bus_if.rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check_val("latency", 32'(edges), 32'(e_lat));
    check_val("rsp_err", 32'(bus_if.rsp_err), 32'(e_err));
    if (!we) check_val("rsp_rdata", bus_if.rsp_rdata, e_rd);
    check_val("write_count", 32'(wr_cnt - w0), 32'(e_wr));
    if (e_wr != 0) check_val("write_edge", 32'(wr_cyc), 32'(n + e_lat));
    check_val("mem_word", mem[6'((addr >> 2) & 32'h3F)], ref_word(addr));
    last_rdata = bus_if.rsp_rdata;
    last_err   = bus_if.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'b10;
      bus_if.req_addr = $urandom; bus_if.req_wdata = $urandom;
      @(posedge clk); #1;
      check_val("hold_valid", 32'(bus_if.rsp_valid), 32'd1);
      check_val("hold_ready", 32'(bus_if.req_ready), 32'd0);
      check_val("hold_err", 32'(bus_if.rsp_err), 32'(e_err));
      if (!we) check_val("hold_rdata", bus_if.rsp_rdata, e_rd);
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("rsp_done", 32'(bus_if.rsp_valid), 32'd0);
    check_val("ready_back", 32'(bus_if.req_ready), 32'd1);
    check_val("no_extra_write", 32'(wr_cnt - w0), 32'(e_wr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w0;
    bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'b00;
    bus_if.req_unsigned = 1'b0; bus_if.req_addr = '0; bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
    #1;
    check_val("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    check_val("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    check_val("rst_mem_r_w", 32'(bus_if.mem_r_w), 32'd0);
    check_val("rst_mem_addr", bus_if.mem_addr, 32'd0);
    check_val("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    check_val("word_store_mem", mem[4], 32'hDEADBEEF);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check_val("word_load", last_rdata, 32'hDEADBEEF);

    preload(32'h20, 32'h80FF7F01);
    xact(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0); check_val("lb_20", last_rdata, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0); check_val("lb_21", last_rdata, 32'hFFFFFFFF);
    xact(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 0); check_val("lb_22", last_rdata, 32'h0000007F);
    xact(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0); check_val("lb_23", last_rdata, 32'h00000001);
    xact(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0); check_val("lbu_21", last_rdata, 32'h000000FF);

    preload(32'h30, 32'h11223344);
    xact(1'b1, 2'b00, 1'b0, 32'h32, 32'h000000AA, 0);
    check_val("sb_32_mem", mem[12], 32'h1122AA44);
    xact(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000BEEF, 0);
    check_val("sh_30_mem", mem[12], 32'hBEEFAA44);

    xact(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 0);
`ifdef LSU_MISALIGN_ERR_EN
    check_val("lh_31_err", 32'(last_err), 32'd1);
    check_val("lh_31_rdata", last_rdata, 32'h0);
`else
    check_val("lh_31_err", 32'(last_err), 32'd0);
    check_val("lh_31_rdata", last_rdata, 32'hFFFFBEEF);
`endif

    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);

    // Reset while the sub-word store's write pulse is up
    preload(32'h34, 32'h55667788);
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'b00;
    bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'h35; bus_if.req_wdata = 32'h000000CC;
    bus_if.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    k = 0;
    while (!bus_if.mem_r_w && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("rst_wr_seen", 32'(bus_if.mem_r_w), 32'd1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_mem_r_w", 32'(bus_if.mem_r_w), 32'd0);
    check_val("rst_mid_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_val("rst_mid_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_no_write", 32'(wr_cnt - w0), 32'd0);
    check_val("rst_mid_mem", mem[13], 32'h55667788);

    for (int i = 0; i < 250; i++) begin
      xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
